// File: rtl/tile_hit_judge.sv
// tile_hit_judge: per-frame hit/miss judge, score/combo/lives and game FSM.
// Ports: frame_clk, Reset (sync, active-high), keycode, TileY0..3, TileS in;
// Score, Combo, Lives, HitLane, MissPulse, Playing, GameOver out (all registered).
// Option: define TILE_JUDGE_COMBO_BONUS_EN for 2 points per hit at combo >= 8.
module tile_hit_judge #(
  parameter logic [9:0] HIT_Y_MIN  = 10'd380,
  parameter logic [9:0] HIT_Y_MAX  = 10'd470,
  parameter logic [2:0] LIVES_INIT = 3'd3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [9:0]  TileY0,
  input  logic [9:0]  TileY1,
  input  logic [9:0]  TileY2,
  input  logic [9:0]  TileY3,
  input  logic [9:0]  TileS,
  output logic [15:0] Score,
  output logic [7:0]  Combo,
  output logic [2:0]  Lives,
  output logic [3:0]  HitLane,
  output logic        MissPulse,
  output logic        Playing,
  output logic        GameOver
);

  localparam logic [7:0] KEY_D  = 8'h07;
  localparam logic [7:0] KEY_F  = 8'h09;
  localparam logic [7:0] KEY_J  = 8'h0D;
  localparam logic [7:0] KEY_K  = 8'h0E;
  localparam logic [7:0] KEY_SP = 8'h2C;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_OVER
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;
  logic [2:0]  lives_q, lives_d;
  logic [3:0]  hit_q, hit_d;
  logic        miss_q, miss_d;
  logic [3:0]  cons_q, cons_d;
  logic        play_q, play_d;
  logic        over_q, over_d;

  logic [9:0]  tile_y [4];
  logic [10:0] bottom [4];
  logic [3:0]  in_zone;
  logic [3:0]  lane_sel;
  logic        press;
  logic [1:0]  pts;
  logic [16:0] score_sum;

  assign tile_y[0] = TileY0;
  assign tile_y[1] = TileY1;
  assign tile_y[2] = TileY2;
  assign tile_y[3] = TileY3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      // 11-bit sum so a tile near the bottom edge never wraps into the zone
      bottom[i]  = {1'b0, tile_y[i]} + {1'b0, TileS};
      in_zone[i] = (bottom[i] >= {1'b0, HIT_Y_MIN}) &&
                   (bottom[i] <= {1'b0, HIT_Y_MAX});
    end
  end

  always_comb begin
    lane_sel = 4'b0000;
    case (keycode)
      KEY_D:   lane_sel = 4'b0001;
      KEY_F:   lane_sel = 4'b0010;
      KEY_J:   lane_sel = 4'b0100;
      KEY_K:   lane_sel = 4'b1000;
      default: lane_sel = 4'b0000;
    endcase
  end

  assign press = (keycode != 8'h00) && (keycode != key_q);

`ifdef TILE_JUDGE_COMBO_BONUS_EN
  assign pts = (combo_q >= 8'd8) ? 2'd2 : 2'd1;
`else
  assign pts = 2'd1;
`endif

  assign score_sum = {1'b0, score_q} + {15'b0, pts};

  always_comb begin
    state_d = state_q;
    key_d   = keycode;
    score_d = score_q;
    combo_d = combo_q;
    lives_d = lives_q;
    hit_d   = 4'b0000;
    miss_d  = 1'b0;
    // consumed lanes re-arm as soon as the tile leaves the zone
    cons_d  = cons_q & in_zone;
    unique case (state_q)
      S_PLAY: begin
        if (press && (lane_sel != 4'b0000)) begin
          if ((lane_sel & in_zone & ~cons_q) != 4'b0000) begin
            hit_d   = lane_sel;
            cons_d  = cons_d | lane_sel;
            combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          end else begin
            miss_d  = 1'b1;
            combo_d = 8'd0;
            if (lives_q <= 3'd1) begin
              lives_d = 3'd0;
              state_d = S_OVER;
            end else begin
              lives_d = lives_q - 3'd1;
            end
          end
        end
      end
      S_IDLE, S_OVER: begin
        if (press && (keycode == KEY_SP)) begin
          state_d = S_PLAY;
          score_d = 16'd0;
          combo_d = 8'd0;
          lives_d = LIVES_INIT;
          cons_d  = 4'b0000;
        end
      end
      default: state_d = S_IDLE;
    endcase
    play_d = (state_d == S_PLAY);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      key_q   <= 8'h00;
      score_q <= 16'd0;
      combo_q <= 8'd0;
      lives_q <= 3'd0;
      hit_q   <= 4'b0000;
      miss_q  <= 1'b0;
      cons_q  <= 4'b0000;
      play_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      score_q <= score_d;
      combo_q <= combo_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      cons_q  <= cons_d;
      play_q  <= play_d;
      over_q  <= over_d;
    end
  end

  assign Score     = score_q;
  assign Combo     = combo_q;
  assign Lives     = lives_q;
  assign HitLane   = hit_q;
  assign MissPulse = miss_q;
  assign Playing   = play_q;
  assign GameOver  = over_q;

endmodule
